// File: rtl/maxpool_window_ctrl_pkg.sv
// Shared types and default geometry for the 2x2 max-pool window controller.
package maxpool_window_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_IMG_W  = 28;
  localparam int unsigned DEF_IMG_H  = 28;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_TOP = 2'd1,
    ROW_BOT = 2'd2,
    FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/maxpool_line_buf.sv
// One-row line buffer: single write port, asynchronous read of the even/odd column pair.
module maxpool_line_buf
  import maxpool_window_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_IMG_W,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] rd_prev,
  output logic signed [DATA_W-1:0] rd_cur
);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        prev_addr;

  // Clearing the LSB gives col-1 for odd columns and never leaves the array range.
  assign prev_addr = addr & ~ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rd_prev = mem[prev_addr];
  assign rd_cur  = mem[addr];

endmodule

// File: rtl/maxpool_window_ctrl.sv
// Streams a row-major frame and emits non-overlapping 2x2 windows for an external pool stage.
module maxpool_window_ctrl
  import maxpool_window_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     win_valid,
  output logic signed [DATA_W-1:0] p00,
  output logic signed [DATA_W-1:0] p01,
  output logic signed [DATA_W-1:0] p10,
  output logic signed [DATA_W-1:0] p11
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  state_t                   state, next_state;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] lb_prev, lb_cur;
  logic                     flush_last, flush_last_d;
  logic                     xfer, col_last, row_last;
  logic                     ctr_clr, lb_we, hold_we, win_we, done_d;

  assign xfer     = s_valid & s_ready;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));

  maxpool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_line_buf (
    .clk     (clk),
    .we      (lb_we),
    .addr    (col),
    .wdata   (s_data),
    .rd_prev (lb_prev),
    .rd_cur  (lb_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_last <= 1'b0;
    end else begin
      state      <= next_state;
      flush_last <= flush_last_d;
    end
  end

  // FLUSH spans two cycles: the last window, then the done cycle, so a start
  // coinciding with done still lands outside IDLE and is ignored.
  always_comb begin
    next_state   = state;
    flush_last_d = 1'b0;
    ctr_clr      = 1'b0;
    lb_we        = 1'b0;
    hold_we      = 1'b0;
    win_we       = 1'b0;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ROW_TOP;
          ctr_clr    = 1'b1;
        end
      end
      ROW_TOP: begin
        if (xfer) begin
          lb_we = 1'b1;
          if (col_last) next_state = row_last ? FLUSH : ROW_BOT;
        end
      end
      ROW_BOT: begin
        if (xfer) begin
          win_we  = col[0];
          hold_we = ~col[0];
          if (col_last) next_state = row_last ? FLUSH : ROW_TOP;
        end
      end
      FLUSH: begin
        if (flush_last) begin
          next_state = IDLE;
        end else begin
          flush_last_d = 1'b1;
          done_d       = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (ctr_clr) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col_last) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Registered handshake, status and window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      hold      <= '0;
      p00       <= '0;
      p01       <= '0;
      p10       <= '0;
      p11       <= '0;
    end else begin
      s_ready   <= (next_state == ROW_TOP) || (next_state == ROW_BOT);
      busy      <= (next_state != IDLE);
      done      <= done_d;
      win_valid <= win_we;
      if (hold_we) hold <= s_data;
      if (win_we) begin
        p00 <= lb_prev;
        p01 <= lb_cur;
        p10 <= hold;
        p11 <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Directed bench: 4x4 and 5x3 instances, stalls, signed data, start-while-busy and mid-frame reset.
module tb_maxpool_window_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start, s_valid, sel;
  logic signed [7:0] s_data;

  logic a_start, a_busy, a_done, a_s_ready, a_win_valid;
  logic signed [7:0] a_p00, a_p01, a_p10, a_p11;
  logic b_start, b_busy, b_done, b_s_ready, b_win_valid;
  logic signed [7:0] b_p00, b_p01, b_p10, b_p11;

  logic m_busy, m_done, m_s_ready, m_win_valid;
  logic [31:0] m_win;

  logic signed [7:0] pix [32];
  logic [31:0] first_win;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign a_start     = start & ~sel;
  assign b_start     = start & sel;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_done      = sel ? b_done      : a_done;
  assign m_s_ready   = sel ? b_s_ready   : a_s_ready;
  assign m_win_valid = sel ? b_win_valid : a_win_valid;
  assign m_win       = sel ? {b_p00, b_p01, b_p10, b_p11} : {a_p00, a_p01, a_p10, a_p11};

  maxpool_window_ctrl #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .win_valid(a_win_valid),
    .p00(a_p00), .p01(a_p01), .p10(a_p10), .p11(a_p11)
  );

  maxpool_window_ctrl #(.DATA_W(8), .IMG_W(5), .IMG_H(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .win_valid(b_win_valid),
    .p00(b_p00), .p01(b_p01), .p10(b_p10), .p11(b_p11)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: s_valid held high; mode 1: 1,0,0,1 then random gaps.
  task automatic run_frame(input int w, input int h, input int npix, input int mode, input int restart_at);
    int k, cyc, nwin, r, c;
    logic v, restarted;
    logic [3:0] pat;
    logic [31:0] ew;
    k = 0; cyc = 0; nwin = 0; restarted = 1'b0; pat = 4'b1001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < npix && cyc < 500) begin
      if (mode == 0)    v = 1'b1;
      else if (cyc < 4) v = pat[2'(cyc)];
      else              v = 1'($urandom_range(0, 1));
      s_valid = v;
      s_data  = pix[5'(k)];
      if (k == restart_at && !restarted) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      check("ready_in_frame", 32'(m_s_ready), 1);
      check("done_in_frame", 32'(m_done), 0);
      @(posedge clk); #1;
      start = 1'b0;
      if (v) begin
        r = k / w;
        c = k % w;
        if ((r % 2 == 1) && (c % 2 == 1) && (r < (h / 2) * 2) && (c < (w / 2) * 2)) begin
          ew = {pix[5'(k - w - 1)], pix[5'(k - w)], pix[5'(k - 1)], pix[5'(k)]};
          check("win_valid", 32'(m_win_valid), 1);
          check("win_data", m_win, ew);
        end else begin
          check("no_win", 32'(m_win_valid), 0);
        end
        k++;
      end else begin
        check("stall_no_win", 32'(m_win_valid), 0);
      end
      if (m_win_valid) begin
        if (nwin == 0) first_win = m_win;
        nwin++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    check("pixels_accepted", k, npix);
    if (npix == w * h) begin
      check("win_count", nwin, (w / 2) * (h / 2));
      @(posedge clk); #1;
      check("done_pulse", 32'(m_done), 1);
      check("busy_at_done", 32'(m_busy), 1);
      check("ready_at_done", 32'(m_s_ready), 0);
      check("no_win_at_done", 32'(m_win_valid), 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_one_cycle", 32'(m_done), 0);
      check("idle_after_done", 32'(m_busy), 0);
      @(posedge clk); #1;
      check("start_at_done_ignored", 32'(m_busy), 0);
      check("idle_ready_low", 32'(m_s_ready), 0);
    end
  endtask

  initial begin
    int mx;
    logic signed [7:0] b;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; sel = 1'b0;
    first_win = '0;
    #12;
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_ready", 32'(a_s_ready), 0);
    check("rst_win_valid", 32'(a_win_valid), 0);
    check("rst_window", {a_p00, a_p01, a_p10, a_p11}, 0);
    check("rst_b_window", {b_p00, b_p01, b_p10, b_p11, 3'b0, b_busy, b_done, b_s_ready, b_win_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    sel = 1'b0;
    run_frame(4, 4, 16, 0, -1);

    sel = 1'b1;
    run_frame(5, 3, 15, 0, -1);

    sel = 1'b0;
    run_frame(4, 4, 16, 1, -1);

    pix[0] = 8'h80; pix[1] = 8'h7f; pix[4] = 8'hff; pix[5] = 8'h00;
    run_frame(4, 4, 16, 0, -1);
    check("signed_window", first_win, 32'h807fff00);
    check("p00_sign", 32'(first_win[31]), 1);
    check("p10_sign", 32'(first_win[15]), 1);
    mx = -1000;
    for (int i = 0; i < 4; i++) begin
      b = first_win[8*i +: 8];
      if (int'(b) > mx) mx = int'(b);
    end
    check("pool_max", mx, 127);

    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    run_frame(4, 4, 7, 0, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(a_busy), 0);
    check("mid_rst_ready", 32'(a_s_ready), 0);
    check("mid_rst_win", {a_p00, a_p01, a_p10, a_p11}, 0);
    check("mid_rst_flags", {a_done, a_win_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_done", 32'(a_done), 0);
      check("post_rst_no_win", 32'(a_win_valid), 0);
      check("post_rst_idle", 32'(a_busy), 0);
    end
    s_valid = 1'b0;
    run_frame(4, 4, 16, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_window_ctrl.md
MAXPOOL_WINDOW_CTRL -- requirements
Module: maxpool_window_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: signed pixel width in bits.
REQ-002 Parameter IMG_W, default 28: feature-map width in pixels, legal range 2..1024.
REQ-003 Parameter IMG_H, default 28: feature-map height in pixels, legal range 2..1024.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: single-cycle frame start request.
REQ-007 Port busy, output, 1: high while a frame is in progress.
REQ-008 Port done, output, 1: one-cycle pulse at frame completion.
REQ-009 Port s_valid, input, 1: an input pixel is present.
REQ-010 Port s_ready, output, 1: the block accepts a pixel.
REQ-011 Port s_data, input, DATA_W, signed: pixel value, row-major order.
REQ-012 Port win_valid, output, 1: window valid; drives the pool in_valid.
REQ-013 Ports p00, p01, p10, p11, output, DATA_W each, signed: 2x2 window; p0x is the upper row, px0 the left column.

Function
REQ-014 A pixel transfer occurs in any cycle where s_valid and s_ready are both 1; otherwise no state advances.
REQ-015 The FSM has four states: IDLE, ROW_TOP, ROW_BOT and FLUSH.
REQ-016 IDLE: s_ready=0, busy=0; on start=1 the FSM goes to ROW_TOP with the row and column counters cleared.
REQ-017 ROW_TOP and ROW_BOT: s_ready=1 and busy=1; start is ignored.
REQ-018 The column counter increments on each transfer and wraps to 0 after IMG_W-1; the row counter increments on each wrap.
REQ-019 ROW_TOP writes each accepted pixel into line buffer entry [col]; on column wrap the FSM goes to ROW_BOT.
REQ-020 ROW_BOT, even col: the pixel is latched in a left-hold register.
REQ-021 ROW_BOT, odd col: the window is registered as p00=lb[col-1], p01=lb[col], p10=hold, p11=s_data, with win_valid=1 in the next cycle.
REQ-022 Window latency: win_valid is asserted exactly 1 cycle after the transfer of the bottom-right pixel; win_valid is 0 in all other cycles.
REQ-023 Odd IMG_W: the last column of every row is accepted and discarded; no partial window is produced.
REQ-024 Odd IMG_H: the last row is accepted in ROW_TOP and discarded; no window is produced for it.
REQ-025 ROW_BOT column wrap with row < IMG_H-1: the FSM goes to ROW_TOP.
REQ-026 Acceptance of the final pixel (row=IMG_H-1, col=IMG_W-1), from either state: the FSM goes to FLUSH.
REQ-027 FLUSH: s_ready=0, busy=1; after 1 cycle (last window emitted) done=1 for one cycle and the FSM returns to IDLE.
REQ-028 Window count per frame is exactly floor(IMG_W/2)*floor(IMG_H/2).
REQ-029 start coincident with done: start is ignored; a new start is accepted only in IDLE.
REQ-030 Counter widths are $clog2(IMG_W) and $clog2(IMG_H) bits; the line buffer is IMG_W x DATA_W and never resizes values.
REQ-031 Window values are passed unmodified, sign preserved.

Reset
REQ-032 rst_n=0 asynchronously forces state=IDLE, counters=0, hold=0, p00..p11=0, win_valid=0, done=0, busy=0, s_ready=0.
REQ-033 Reset mid-frame aborts the frame: no done pulse and no further windows.
REQ-034 After a mid-frame reset the next start begins a fresh frame; line buffer contents need not be cleared.

Structure
REQ-035 A shared package holds the FSM state enum (IDLE/ROW_TOP/ROW_BOT/FLUSH) and the default DATA_W/IMG_W/IMG_H constants.
REQ-036 The line buffer is one sub-module, maxpool_line_buf: single-port write, two-entry read of [col-1] and [col], asynchronous read, no reset on storage.
REQ-037 The block does not instantiate the pooling datapath; it is wired externally with win_valid->in_valid.

Verification
REQ-038 IMG_W=4, IMG_H=4, pixels 0..15 with s_valid held high -> windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15) each 1 cycle after pixels 5/7/13/15; done 1 cycle after the last window.
REQ-039 IMG_W=5, IMG_H=3, pixels 0..14 -> exactly 2 windows, (0,1,5,6) and (2,3,7,8); pixels 4, 9 and 10..14 produce none; done asserted.
REQ-040 4x4 frame with s_valid toggling 1,0,0,1... and random gaps -> same 4 windows as REQ-038, with no window in any stall cycle.
REQ-041 Signed values: top row -128,127, bottom row -1,0 -> p00=-128, p01=127, p10=-1, p11=0, sign bits intact; an external pool yields 127.
REQ-042 start pulsed while busy, and rst_n dropped after pixel 6 of a 4x4 frame -> start is ignored; after reset, outputs are 0, no done pulse, and a new start runs a clean frame matching REQ-038.
